// File: rtl/uart8.sv
// rtl/uart8.sv - 8N1 UART, 16x oversampled receiver and transmitter on one clock.
// Optional macro UART8_RX_SYNC_EN adds a two-flop synchronizer on rxIn.
module uart8 #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxEn,
  input  logic       rxIn,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] rxOut,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txBusy,
  output logic       txDone,
  output logic       txOut
);

  localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RX_CW  = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int TX_CW  = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic rx_line;

`ifdef UART8_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], rxIn};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= sync_d;
  end

  assign rx_line = sync_q[1];
`else
  assign rx_line = rxIn;
`endif

  rx_state_t        rx_state_q, rx_state_d;
  logic [RX_CW-1:0] rx_div_q, rx_div_d;
  logic [3:0]       rx_tick_q, rx_tick_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_out_q, rx_out_d;
  logic             rx_busy_q, rx_busy_d;
  logic             rx_done_q, rx_done_d;
  logic             rx_err_q, rx_err_d;
  logic             rx_tick;

  assign rx_tick = (rx_div_q == RX_CW'(RX_DIV - 1));

  // Tick counter free-runs; it is re-phased to the falling edge of each start bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_tick ? '0 : rx_div_q + RX_CW'(1);
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_out_d   = rx_out_q;
    rx_busy_d  = rx_busy_q;
    rx_done_d  = 1'b0;
    rx_err_d   = rx_err_q;
    if (!rxEn) begin
      rx_state_d = RX_IDLE;
      rx_busy_d  = 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_line == 1'b0) begin
            rx_state_d = RX_START;
            rx_div_d   = '0;
            rx_tick_d  = '0;
          end
        end
        RX_START: begin
          if (rx_line != 1'b0) begin
            rx_state_d = RX_IDLE;
          end else if (rx_tick) begin
            if (rx_tick_q == 4'd7) begin
              rx_state_d = RX_DATA;
              rx_busy_d  = 1'b1;
              rx_err_d   = 1'b0;
              rx_tick_d  = '0;
              rx_bit_d   = '0;
            end else begin
              rx_tick_d = rx_tick_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_tick_d = rx_tick_q + 4'd1;
            if (rx_tick_q == 4'd15) begin
              rx_shift_d = {rx_line, rx_shift_q[7:1]};
              rx_bit_d   = rx_bit_q + 3'd1;
              if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_tick_d = rx_tick_q + 4'd1;
            if (rx_tick_q == 4'd15) begin
              rx_busy_d = 1'b0;
              if (rx_line == 1'b1) begin
                rx_out_d   = rx_shift_q;
                rx_done_d  = 1'b1;
                rx_state_d = RX_IDLE;
              end else begin
                rx_err_d   = 1'b1;
                rx_state_d = RX_WAIT_IDLE;
              end
            end
          end
        end
        RX_WAIT_IDLE: begin
          if (rx_line == 1'b1) rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_div_q   <= '0;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_out_q   <= '0;
      rx_busy_q  <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_out_q   <= rx_out_d;
      rx_busy_q  <= rx_busy_d;
      rx_done_q  <= rx_done_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign rxBusy = rx_busy_q;
  assign rxDone = rx_done_q;
  assign rxErr  = rx_err_q;
  assign rxOut  = rx_out_q;

  tx_state_t        tx_state_q, tx_state_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_busy_q, tx_busy_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_out_q, tx_out_d;
  logic             tx_end;

  assign tx_end = (tx_cnt_q == TX_CW'(TX_DIV - 1));

  // txOut is registered, so each bit value is loaded on the edge that ends the previous bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_end ? '0 : tx_cnt_q + TX_CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    tx_out_d   = tx_out_q;
    if (!txEn) begin
      tx_state_d = TX_IDLE;
      tx_cnt_d   = '0;
      tx_busy_d  = 1'b0;
      tx_out_d   = 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_d = '0;
          if (txStart) begin
            tx_shift_d = txIn;
            tx_busy_d  = 1'b1;
            tx_out_d   = 1'b0;
            tx_state_d = TX_START;
          end
        end
        TX_START: begin
          if (tx_end) begin
            tx_out_d   = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = '0;
            tx_state_d = TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_end) begin
            if (tx_bit_q == 3'd7) begin
              tx_out_d   = 1'b1;
              tx_state_d = TX_STOP;
            end else begin
              tx_out_d   = tx_shift_q[0];
              tx_shift_d = {1'b0, tx_shift_q[7:1]};
              tx_bit_d   = tx_bit_q + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (tx_end) begin
            tx_busy_d  = 1'b0;
            tx_done_d  = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
      tx_out_q   <= tx_out_d;
    end
  end

  assign txBusy = tx_busy_q;
  assign txDone = tx_done_q;
  assign txOut  = tx_out_q;

endmodule

// File: tb/tb_uart8.sv
// tb/tb_uart8.sv - scoreboard bench for uart8 (RX_DIV=10, TX_DIV=160, clock period 10).
module tb_uart8;

  localparam int CLK_RATE = 1536000;
  localparam int BAUD     = 9600;
  localparam int BIT_T    = 1600;
  localparam int SLOW_T   = 1648;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxEn = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic       rx_pin;
  logic       rxBusy, rxDone, rxErr;
  logic [7:0] rxOut;
  logic       txEn = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] txIn = 8'h00;
  logic       txBusy, txDone, txOut;

  int total = 0;
  int bad = 0;
  int rx_busy_cyc = 0;
  int rx_done_cyc = 0;
  int rx_done_rise = 0;
  int tx_done_cyc = 0;
  int tx_done_rise = 0;
  logic rx_done_prev = 1'b0;
  logic tx_done_prev = 1'b0;
  logic [7:0] exp_q[$];

  assign rx_pin = loop ? txOut : rx_drv;

  uart8 #(.CLOCK_RATE(CLK_RATE), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .reset(reset),
    .rxEn(rxEn), .rxIn(rx_pin), .rxBusy(rxBusy), .rxDone(rxDone), .rxErr(rxErr), .rxOut(rxOut),
    .txEn(txEn), .txStart(txStart), .txIn(txIn), .txBusy(txBusy), .txDone(txDone), .txOut(txOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int bt);
    rx_drv = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      #(bt);
    end
    rx_drv = 1'b1;
    #(bt);
  endtask

  always @(negedge clk) begin
    if (rxBusy) rx_busy_cyc++;
    if (rxDone) begin
      rx_done_cyc++;
      if (!rx_done_prev) rx_done_rise++;
      if (exp_q.size() == 0) check("rx_unexpected", {24'd0, rxOut}, 32'h100);
      else check("rx_byte", {24'd0, rxOut}, {24'd0, exp_q.pop_front()});
    end
    rx_done_prev = rxDone;
    if (txDone) begin
      tx_done_cyc++;
      if (!tx_done_prev) tx_done_rise++;
    end
    tx_done_prev = txDone;
  end

  initial begin
    int b0, d0, r0, t0, tr0;
    logic [9:0] frame;
    logic [7:0] tx_byte;

    repeat (10) @(negedge clk);
    check("rst_rxBusy", rxBusy, 0);
    check("rst_rxDone", rxDone, 0);
    check("rst_rxErr", rxErr, 0);
    check("rst_rxOut", rxOut, 0);
    check("rst_txBusy", txBusy, 0);
    check("rst_txDone", txDone, 0);
    check("rst_txOut", txOut, 1);
    reset = 1'b0;
    rxEn = 1'b1;
    repeat (20) @(negedge clk);

    // 0x55 with a 3% slow line
    b0 = rx_busy_cyc; d0 = rx_done_cyc; r0 = rx_done_rise;
    exp_q.push_back(8'h55);
    send_byte(8'h55, SLOW_T);
    #(BIT_T);
    check("slow_busy_seen", rx_busy_cyc > b0, 1);
    check("slow_done_cycles", rx_done_cyc - d0, 1);
    check("slow_done_pulses", rx_done_rise - r0, 1);
    check("slow_rxOut", rxOut, 8'h55);
    check("slow_rxErr", rxErr, 0);
    check("slow_busy_end", rxBusy, 0);

    // short glitch on idle line
    @(negedge clk);
    b0 = rx_busy_cyc; d0 = rx_done_cyc;
    rx_drv = 1'b0;
    #(320);
    rx_drv = 1'b1;
    #(2 * BIT_T);
    check("glitch_busy", rx_busy_cyc - b0, 0);
    check("glitch_done", rx_done_cyc - d0, 0);
    check("glitch_err", rxErr, 0);

    // receiver disabled
    @(negedge clk);
    rxEn = 1'b0;
    b0 = rx_busy_cyc; d0 = rx_done_cyc;
    send_byte(8'hA3, BIT_T);
    #(BIT_T);
    check("dis_busy", rx_busy_cyc - b0, 0);
    check("dis_done", rx_done_cyc - d0, 0);
    check("dis_err", rxErr, 0);
    check("dis_rxOut", rxOut, 8'h55);
    rxEn = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'hA3);
    send_byte(8'hA3, BIT_T);
    #(BIT_T);
    check("en_rxOut", rxOut, 8'hA3);

    // framing error: line held low through the stop slot, released 300 later
    @(negedge clk);
    d0 = rx_done_cyc;
    rx_drv = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      rx_drv = (i % 2 == 0) ? 1'b1 : 1'b0;
      #(BIT_T);
    end
    rx_drv = 1'b0;
    #(1200);
    check("ferr_err_low", rxErr, 1);
    check("ferr_busy_low", rxBusy, 0);
    #(700);
    rx_drv = 1'b1;
    #(BIT_T);
    check("ferr_err", rxErr, 1);
    check("ferr_done", rx_done_cyc - d0, 0);
    check("ferr_rxOut", rxOut, 8'hA3);

    // TX loopback 0xA5 with an ignored mid-frame start
    tx_byte = 8'hA5;
    frame = {1'b1, tx_byte, 1'b0};
    loop = 1'b1;
    txEn = 1'b1;
    t0 = tx_done_cyc; tr0 = tx_done_rise; d0 = rx_done_cyc;
    exp_q.push_back(tx_byte);
    @(negedge clk);
    txIn = tx_byte;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    txIn = 8'h00;
    repeat (80) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx_bit%0d", k), txOut, frame[k]);
      if (k == 3) begin
        check("tx_busy_mid", txBusy, 1);
        txIn = 8'hFF;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        repeat (159) @(negedge clk);
      end else if (k < 9) begin
        repeat (160) @(negedge clk);
      end
    end
    repeat (160) @(negedge clk);
    check("tx_done_cycles", tx_done_cyc - t0, 1);
    check("tx_done_pulses", tx_done_rise - tr0, 1);
    check("tx_busy_end", txBusy, 0);
    check("tx_idle_out", txOut, 1);
    check("loop_rx_done", rx_done_cyc - d0, 1);
    check("loop_rxOut", rxOut, tx_byte);
    check("loop_err_clr", rxErr, 0);
    loop = 1'b0;
    repeat (20) @(negedge clk);

    // reset mid-frame on both directions
    d0 = rx_done_cyc; t0 = tx_done_cyc;
    fork
      send_byte(8'h3C, BIT_T);
    join_none
    txIn = 8'h0F;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    #(4 * BIT_T);
    check("pre_rst_rxBusy", rxBusy, 1);
    check("pre_rst_txBusy", txBusy, 1);
    reset = 1'b1;
    rxEn = 1'b0;
    #1;
    check("mid_rst_rxBusy", rxBusy, 0);
    check("mid_rst_txBusy", txBusy, 0);
    check("mid_rst_txOut", txOut, 1);
    check("mid_rst_rxOut", rxOut, 0);
    check("mid_rst_rxErr", rxErr, 0);
    #(7 * BIT_T);
    @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("rst_no_rxdone", rx_done_cyc - d0, 0);
    check("rst_no_txdone", tx_done_cyc - t0, 0);
    check("rst_txBusy_after", txBusy, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart8.md
Name: uart8

Overview:
- 8N1 UART (8 data bits, no parity, 1 stop bit) with independent receiver and transmitter sharing one clock.
- Baud timing is derived from the system clock.
- Receiver oversamples at 16x, samples each bit mid-period and flags framing errors.
- Sits between a board pin pair and byte-level host logic.

Parameters:
- CLOCK_RATE, 12000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate in baud.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- rxEn  input  1  receiver enable; low forces receiver idle.
- rxIn  input  1  serial line in; idles high.
- rxBusy  output  1  high from validated start bit to end of stop bit.
- rxDone  output  1  one-cycle pulse when a byte with a valid stop bit is received.
- rxErr  output  1  framing error flag (stop bit sampled low).
- rxOut  output  8  last correctly received byte.
- txEn  input  1  transmitter enable.
- txStart  input  1  start request, sampled when idle.
- txIn  input  8  byte to send, captured on accept.
- txBusy  output  1  high while a frame is being sent.
- txDone  output  1  one-cycle pulse after the stop bit completes.
- txOut  output  1  serial line out; idles high.

Behaviour:
- Reset values: rxBusy=0, rxDone=0, rxErr=0, rxOut=0, txBusy=0, txDone=0, txOut=1. Both FSMs return to IDLE.
- Reset asserted mid-frame aborts the frame immediately. No done pulse is produced.
- RX tick: every RX_DIV=CLOCK_RATE/(BAUD_RATE*16) clocks (integer division; 78 at defaults).
- TX bit period: TX_DIV=CLOCK_RATE/BAUD_RATE clocks (1250 at defaults).
- RX FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when rxEn=1 and rxIn=0, go to START and clear the tick counter.
  - START: rxIn must stay low for 8 ticks (mid start bit). If rxIn returns high before then, it is a glitch: go back to IDLE with no flags. If validated, set rxBusy=1, clear rxErr, go to DATA.
  - DATA: every 16 ticks sample rxIn, shift it in LSB first. After 8 samples go to STOP.
  - STOP: after 16 ticks sample rxIn.
    - If high: rxOut<=shift register, rxDone=1 for exactly one clock, rxBusy=0, go to IDLE.
    - If low: rxErr=1, no rxDone pulse, rxOut unchanged, rxBusy=0, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxIn=1, then go to IDLE.
- rxErr stays high until the next validated start bit or reset.
- Mid-bit sampling must tolerate at least ±3% baud mismatch over the 10-bit frame.
- rxEn=0 in any RX state: return to IDLE, rxBusy=0. rxOut and rxErr are held.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on txEn=1 and txStart=1, capture txIn, set txBusy=1, drive txOut=0 from the next clock for TX_DIV clocks.
  - DATA: send 8 bits LSB first, TX_DIV clocks each.
  - STOP: drive txOut=1 for TX_DIV clocks, then txBusy=0, txDone=1 for one clock, go to IDLE.
- txStart while txBusy is ignored.
- txEn=0 aborts the frame: txOut=1, txBusy=0, no txDone pulse.
- rxIn=X/Z before first drive: the receiver must not leave IDLE unless rxIn is a definite 0.

Optional Feature:
- Macro UART8_RX_SYNC_EN.
- Defined: rxIn passes through a two-flop synchronizer, reset to 1, before the RX FSM. All RX timing shifts by 2 clocks.
- Undefined: rxIn is used directly. The line is assumed synchronous to clk.

Test Plan:
- Reset 10 cycles, then rxEn=1. Send 0x55 (start, LSB first, stop) with bit time 1075 sim units (about 3% slow vs 1042) -> rxBusy during frame, rxOut=0x55, one-cycle rxDone, rxErr=0.
- Send 0x55 but hold the line low through the stop-bit slot, high 300 units later -> rxErr=1, no rxDone, rxOut keeps its prior value, receiver returns to IDLE once line high.
- 20 µs low pulse on idle rxIn (under half a bit) -> rxBusy never asserts, no rxDone/rxErr.
- rxEn=0, send 0xA3 -> no rxBusy, rxDone or rxErr. Then rxEn=1, send 0xA3 -> rxOut=0xA3.
- txEn=1, txIn=0xA5, pulse txStart, loop txOut to rxIn -> txOut pattern 0,1,0,1,0,0,1,0,1,1 at 1250 clocks/bit; txDone pulse; rxOut=0xA5. txStart pulsed mid-frame is ignored.
- Assert reset mid-RX and mid-TX frame -> outputs return to reset values immediately; no done pulses.
